mul_add_seq: RTL

Sequential multiply-accumulate unit that reconstructs a dividend from a division result: P = Q × B + R. It is the inverse companion of the team's sequential divider. It checks divider outputs in self-test paths and rebuilds operands in the arithmetic datapath. Computation is radix-2 shift-add, one multiplier bit per clock, with the same start/ok/err handshake as the divider.

---
 rtl/mul_add_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mul_add_seq.sv
// mul_add_seq: sequential radix-2 shift-add unit computing P = Q*B + R.
// Rebuilds a dividend from a divider result, one multiplier bit per clock.
// Optional build macro: REMAINDER_CHECK_EN (flags R >= B as an error).
module mul_add_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] P,
  output logic             ok,
  output logic             err,
  output logic             busy
);

  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [AW-1:0]    mb_q, mb_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             fail;
`ifdef REMAINDER_CHECK_EN
  logic             rem_bad_q, rem_bad_d;
`endif

  // Next-state and datapath: accept, shift-add iterate, resolve result, hold.
  always_comb begin
    state_d = state_q;
    mq_d    = mq_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    ok_d    = ok_q;
    err_d   = err_q;
`ifdef REMAINDER_CHECK_EN
    rem_bad_d = rem_bad_q;
    fail      = (|acc_q[AW-1:WIDTH]) | rem_bad_q;
`else
    fail      = |acc_q[AW-1:WIDTH];
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mq_d    = Q;
          mb_d    = AW'(B);
          acc_d   = AW'(R);
          cnt_d   = '0;
          ok_d    = 1'b0;
          err_d   = 1'b0;
`ifdef REMAINDER_CHECK_EN
          rem_bad_d = (R >= B);
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        if (mq_q[0]) begin
          acc_d = acc_q + mb_q;
        end
        mq_d  = mq_q >> 1;
        mb_d  = mb_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        // High half nonzero means the exact result does not fit in WIDTH bits.
        p_d     = acc_q[WIDTH-1:0];
        err_d   = fail;
        ok_d    = ~fail;
        state_d = DONE;
      end
      DONE: begin
        if (!start) begin
          ok_d    = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == FINISH);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mq_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef REMAINDER_CHECK_EN
      rem_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mq_q    <= mq_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
`ifdef REMAINDER_CHECK_EN
      rem_bad_q <= rem_bad_d;
`endif
    end
  end

  assign P    = p_q;
  assign ok   = ok_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule
